stc_codeword_streamer: RTL and testbench

- Parametrised successor to the fixed 16-entry space-time codeword lookup. Holds a run-time-writable codebook of N_CW codeword matrices, each ROWS x COLS complex symbols with EW-bit real and imaginary parts.
- On an accepted request it streams the selected codeword one component per beat over a valid/ready interface.
- Feeds the ML detector's metric datapath, replacing combinational per-element muxing with a sequenced, back-pressurable stream.

---
 rtl/stc_codeword_streamer_if.sv | 43 ++++
 rtl/stc_codeword_streamer.sv | 75 +++++++
 tb/tb_stc_codeword_streamer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/stc_codeword_streamer_if.sv
// stc_codeword_streamer_if: codebook write, request and output-beat signals of the codeword streamer (abort present when STC_STREAM_ABORT_EN is defined)
interface stc_codeword_streamer_if #(
  parameter int N_CW = 16,
  parameter int ROWS = 4,
  parameter int COLS = 2,
  parameter int EW   = 2
);
  localparam int WW = ROWS * COLS * 2 * EW;
  localparam int IW = N_CW > 1 ? $clog2(N_CW) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [WW-1:0] cfg_data;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_idx;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_data;
  logic          out_re;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic          idx_err;
`ifdef STC_STREAM_ABORT_EN
  logic          abort;
`endif
  modport master (
`ifdef STC_STREAM_ABORT_EN
    output abort,
`endif
    output cfg_we, cfg_idx, cfg_data, req_valid, req_idx, out_ready,
    input  req_ready, out_valid, out_data, out_re, out_row, out_col, out_last, idx_err
  );
  modport slave (
`ifdef STC_STREAM_ABORT_EN
    input  abort,
`endif
    input  cfg_we, cfg_idx, cfg_data, req_valid, req_idx, out_ready,
    output req_ready, out_valid, out_data, out_re, out_row, out_col, out_last, idx_err
  );
endinterface

// File: rtl/stc_codeword_streamer.sv
// stc_codeword_streamer: writable codebook of ROWS x COLS complex codewords streamed one component per beat; STC_STREAM_ABORT_EN adds a stream abort input
module stc_codeword_streamer #(
  parameter int N_CW = 16,
  parameter int ROWS = 4,
  parameter int COLS = 2,
  parameter int EW   = 2
) (
  input logic clk,
  input logic rst_n,
  stc_codeword_streamer_if.slave bus
);
  localparam int WW = ROWS * COLS * 2 * EW;
  localparam int NB = ROWS * COLS * 2;
  localparam int BW = $clog2(NB);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t        state;
  logic [WW-1:0] mem [N_CW];
  logic [WW-1:0] sr;
  logic [BW-1:0] cnt;
  logic          hs;
  logic          abort;
  logic          req_ok;
  assign hs     = bus.out_valid & bus.out_ready;
  assign req_ok = 32'(bus.req_idx) < N_CW;
`ifdef STC_STREAM_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif
  // beat position decoded from the counter: even beats carry the real part
  assign bus.out_data = sr[WW-1 -: EW];
  assign bus.out_re   = ~cnt[0];
  assign bus.out_row  = RW'(32'(cnt) / (2 * COLS));
  assign bus.out_col  = CW'((32'(cnt) / 2) % COLS);
  // codebook storage; out-of-range write addresses are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N_CW; i++) mem[i] <= '0;
    else if (bus.cfg_we && 32'(bus.cfg_idx) < N_CW) mem[bus.cfg_idx] <= bus.cfg_data;
  // request/stream sequencer; the shift register snapshots the entry so later writes cannot disturb a stream
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      sr            <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.idx_err   <= 1'b0;
    end else begin
      bus.idx_err <= 1'b0;
      if (state == IDLE) begin
        if (bus.req_valid && req_ok) begin
          state         <= STREAM;
          sr            <= mem[bus.req_idx];
          cnt           <= '0;
          bus.req_ready <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_last  <= 1'b0;
        end else bus.idx_err <= bus.req_valid;
      end else if ((hs && bus.out_last) || abort) begin
        state         <= IDLE;
        sr            <= '0;
        cnt           <= '0;
        bus.req_ready <= 1'b1;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end else if (hs) begin
        sr           <= sr << EW;
        cnt          <= cnt + 1'b1;
        bus.out_last <= cnt == BW'(NB - 2);
      end
    end
endmodule

// File: tb/tb_stc_codeword_streamer.sv
// tb_stc_codeword_streamer: randomized and directed checks of the codeword streamer against a codebook reference model
module tb_stc_codeword_streamer;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] ref_cb [16];
  logic [31:0] ref_cb1 [12];
  always #5 clk = ~clk;
  stc_codeword_streamer_if b0 ();
  stc_codeword_streamer_if #(.N_CW(12)) b1 ();
  stc_codeword_streamer d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  stc_codeword_streamer #(.N_CW(12)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {valid,data,re,row,col,last} for beat k of codeword cw
  function automatic logic [7:0] beat(input logic [31:0] cw, input int k);
    int e = k / 2;
    logic [3:0] el = cw[31 - 4 * e -: 4];
    logic [1:0] d = (k % 2 == 0) ? el[3:2] : el[1:0];
    return {1'b1, d, k % 2 == 0, 2'(e / 2), 1'(e % 2), k == 15};
  endfunction

  task automatic wr(input int idx, input logic [31:0] data);
    b0.cfg_we = 1; b0.cfg_idx = 4'(idx); b0.cfg_data = data;
    @(negedge clk);
    b0.cfg_we = 0;
    ref_cb[idx] = data;
  endtask

  // request at a negedge, optionally with a same-cycle write; returns the snapshot expected
  task automatic req(input int idx, input bit we, input int widx, input logic [31:0] wdata, output logic [31:0] snap);
    snap = ref_cb[idx];
    b0.req_valid = 1; b0.req_idx = 4'(idx);
    b0.cfg_we = we; b0.cfg_idx = 4'(widx); b0.cfg_data = wdata;
    @(negedge clk);
    b0.req_valid = 0; b0.cfg_we = 0;
    if (we) ref_cb[widx] = wdata;
  endtask

  // pat 0: always ready, 1: 1,0,0,1 repeating, 2: random; optional write when beat wbeat is on the bus
  task automatic collect(input logic [31:0] cw, input int pat, input int wbeat, input int widx, input logic [31:0] wdata);
    int k = 0;
    int cyc = 0;
    bit rdy;
    bit done = 0;
    logic [3:0] p = 4'b1001;
    while (k < 16) begin
      chk($sformatf("beat%0d", k), {b0.out_valid, b0.out_data, b0.out_re, b0.out_row, b0.out_col, b0.out_last}, beat(cw, k));
      if (k == wbeat && !done) begin
        b0.cfg_we = 1; b0.cfg_idx = 4'(widx); b0.cfg_data = wdata;
        ref_cb[widx] = wdata;
        done = 1;
      end
      rdy = pat == 0 ? 1'b1 : pat == 1 ? p[3 - cyc % 4] : 1'($urandom_range(0, 1));
      b0.out_ready = rdy;
      @(negedge clk);
      b0.cfg_we = 0;
      if (rdy) k++;
      cyc++;
    end
    chk("end", {b0.out_valid, b0.req_ready, b0.out_last}, 3'b010);
  endtask

  task automatic collect1(input logic [31:0] cw);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("n12_beat%0d", k), {b1.out_valid, b1.out_data, b1.out_re, b1.out_row, b1.out_col, b1.out_last}, beat(cw, k));
      @(negedge clk);
    end
    chk("n12_end", {b1.out_valid, b1.req_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] s;
    int idx;
    for (int i = 0; i < 16; i++) ref_cb[i] = '0;
    for (int i = 0; i < 12; i++) ref_cb1[i] = '0;
    b0.cfg_we = 0; b0.cfg_idx = 0; b0.cfg_data = 0; b0.req_valid = 0; b0.req_idx = 0; b0.out_ready = 1;
    b1.cfg_we = 0; b1.cfg_idx = 0; b1.cfg_data = 0; b1.req_valid = 0; b1.req_idx = 0; b1.out_ready = 1;
`ifdef STC_STREAM_ABORT_EN
    b0.abort = 0; b1.abort = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset", {b0.req_ready, b0.out_valid, b0.out_data, b0.out_re, b0.out_row, b0.out_col, b0.out_last, b0.idx_err}, 10'b1_0_00_1_00_0_0_0);
    rst_n = 1;
    @(negedge clk);
    // basic stream
    wr(0, 32'h44C444C4);
    req(0, 0, 0, 0, s);
    collect(s, 0, -1, 0, 0);
    // stalls
    wr(5, 32'h44C4C11C);
    req(5, 0, 0, 0, s);
    collect(s, 1, -1, 0, 0);
    // same-cycle write and acceptance, then the new value
    req(3, 1, 3, 32'h44C44334, s);
    collect(s, 0, -1, 0, 0);
    @(negedge clk);
    req(3, 0, 0, 0, s);
    collect(s, 0, -1, 0, 0);
    // rewrite during own stream
    wr(1, 32'h9A3C_5E71);
    req(1, 0, 0, 0, s);
    collect(s, 2, 4, 1, 32'h1234_5678);
    req(1, 0, 0, 0, s);
    collect(s, 0, -1, 0, 0);
    // randomized traffic
    for (int t = 0; t < 8; t++) begin
      wr($urandom_range(0, 15), $urandom);
      idx = $urandom_range(0, 15);
      req(idx, 0, 0, 0, s);
      collect(s, 2, $urandom_range(0, 20), $urandom_range(0, 15), $urandom);
    end
    // N_CW=12 instance: out-of-range request and write
    b1.req_valid = 1; b1.req_idx = 4'd13;
    @(negedge clk);
    b1.req_valid = 0;
    chk("oor_pulse", {b1.idx_err, b1.req_ready, b1.out_valid}, 3'b110);
    @(negedge clk);
    chk("oor_clear", {b1.idx_err, b1.req_ready, b1.out_valid}, 3'b010);
    b1.cfg_we = 1; b1.cfg_idx = 4'd11; b1.cfg_data = 32'hC4_4C_13_31;
    @(negedge clk);
    ref_cb1[11] = 32'hC4_4C_13_31;
    b1.cfg_idx = 4'd14; b1.cfg_data = 32'hFFFF_FFFF;
    @(negedge clk);
    b1.cfg_we = 0;
    for (int i = 0; i < 12; i += 9) begin
      b1.req_valid = 1; b1.req_idx = 4'(i + (i == 9 ? 2 : 2));
      @(negedge clk);
      b1.req_valid = 0;
      collect1(ref_cb1[i + 2]);
    end
    // asynchronous reset mid-stream
    req(5, 0, 0, 0, s);
    repeat (7) @(negedge clk);
    chk("pre_rst_beat7", {b0.out_valid, b0.out_data, b0.out_re, b0.out_row, b0.out_col, b0.out_last}, beat(s, 7));
    #2 rst_n = 0;
    #1 chk("async_rst", {b0.out_valid, b0.req_ready, b0.out_last}, 3'b010);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) ref_cb[i] = '0;
    req(5, 0, 0, 0, s);
    collect(s, 0, -1, 0, 0);
`ifdef STC_STREAM_ABORT_EN
    wr(0, 32'h44C444C4);
    req(0, 0, 0, 0, s);
    repeat (7) @(negedge clk);
    b0.abort = 1; b0.out_ready = 0;
    @(negedge clk);
    b0.abort = 0; b0.out_ready = 1;
    chk("abort", {b0.out_valid, b0.out_last, b0.req_ready}, 3'b001);
    req(0, 0, 0, 0, s);
    collect(s, 0, -1, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
